// File: rtl/unpack_pkg.sv
// Shared definitions for the wide-word unpacker: default widths, derived
// beat count / counter width and the FSM state encoding.
package unpack_pkg;

  localparam int WIDE_W_DEF   = 128;
  localparam int NARROW_W_DEF = 32;
  localparam int BEATS_DEF    = WIDE_W_DEF / NARROW_W_DEF;
  localparam int CNT_W_DEF    = (BEATS_DEF > 1) ? $clog2(BEATS_DEF) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/unpack_beat_sel.sv
// Combinational beat selector: picks the NARROW_W slice of the held wide word
// that corresponds to beat index cnt.
// Build option: define UNPACK_MSB_FIRST_EN to emit the most-significant slice
// first; otherwise the least-significant slice goes out first.
module unpack_beat_sel
  import unpack_pkg::*;
#(
  parameter int WIDE_W   = WIDE_W_DEF,
  parameter int NARROW_W = NARROW_W_DEF,
  localparam int BEATS   = WIDE_W / NARROW_W,
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic [WIDE_W-1:0]   buffer,
  input  logic [CNT_W-1:0]    cnt,
  output logic [NARROW_W-1:0] beat
);

  logic [NARROW_W-1:0] slices [BEATS];

  // Lay the wide word out as an array of beats in emission order, so the
  // beat counter indexes it directly.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
`ifdef UNPACK_MSB_FIRST_EN
    assign slices[gi] = buffer[(BEATS-1-gi)*NARROW_W +: NARROW_W];
`else
    assign slices[gi] = buffer[gi*NARROW_W +: NARROW_W];
`endif
  end

  assign beat = slices[cnt];

endmodule

// File: rtl/wide_word_unpacker.sv
// Wide-to-narrow unpacker: takes one WIDE_W word over a valid/ready handshake,
// holds it, and replays it as BEATS narrow beats on a valid/ready stream.
// A new word can be taken on the last-beat transfer for zero-bubble streaming.
// Build option: UNPACK_MSB_FIRST_EN selects MSB-first beat order (see
// unpack_beat_sel); default is LSB-first.
module wide_word_unpacker
  import unpack_pkg::*;
#(
  parameter int WIDE_W   = WIDE_W_DEF,
  parameter int NARROW_W = NARROW_W_DEF,
  localparam int BEATS   = WIDE_W / NARROW_W,
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                clk,
  input  logic                areset_n,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [WIDE_W-1:0]   in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NARROW_W-1:0] out_data,
  output logic [CNT_W-1:0]    out_idx,
  output logic                out_last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [WIDE_W-1:0] buf_reg;
  logic              load;
  logic              is_send;
  logic              is_last;

  assign is_send = (state_reg == ST_SEND);
  assign is_last = is_send && (cnt_reg == LAST_IDX);

  // State, beat counter and word buffer; the buffer only changes on acceptance.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      buf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (load) begin
        buf_reg <= in_data;
      end
    end
  end

  // Next-state logic: flush beats any transfer; the last beat either reloads
  // (back-to-back) or returns to idle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (flush) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else if (out_ready) begin
          if (is_last) begin
            cnt_next = '0;
            if (in_valid) begin
              load = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // in_ready depends on out_ready/flush and registered state only, never on
  // in_valid, so no combinational loop through an upstream handshake.
  assign in_ready  = !is_send || (out_ready && is_last && !flush);
  assign out_valid = is_send;
  assign out_idx   = cnt_reg;
  assign out_last  = is_last;

  unpack_beat_sel #(
    .WIDE_W   (WIDE_W),
    .NARROW_W (NARROW_W)
  ) u_beat_sel (
    .buffer (buf_reg),
    .cnt    (cnt_reg),
    .beat   (out_data)
  );

endmodule

// File: tb/tb_wide_word_unpacker.sv
// Self-checking bench for wide_word_unpacker: table-driven directed vectors,
// a hand-written mid-word reset sequence and a random valid/ready stress run.
module tb_wide_word_unpacker;

  logic         clk = 1'b0;
  logic         areset_n;
  logic         flush;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_idx;
  logic         out_last;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] W2 = 128'h88888888_77777777_66666666_55555555;

  wide_word_unpacker dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [127:0] din;
    logic         ordy;
    logic         fl;
    logic         e_ir;
    logic         e_ov;
    logic [1:0]   e_idx;
    logic         e_last;
    logic [127:0] e_word;
  } vec_t;

  vec_t vecs [64];
  int   n_vec = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  beat_t sb[$];

  function automatic logic [31:0] exp_beat(input logic [127:0] w, input logic [1:0] idx);
    int k;
`ifdef UNPACK_MSB_FIRST_EN
    k = 3 - int'(idx);
`else
    k = int'(idx);
`endif
    return w[k*32 +: 32];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic iv, input logic [127:0] din, input logic ordy,
                         input logic fl, input logic e_ir, input logic e_ov,
                         input logic [1:0] e_idx, input logic e_last,
                         input logic [127:0] e_word);
    vecs[n_vec].iv     = iv;
    vecs[n_vec].din    = din;
    vecs[n_vec].ordy   = ordy;
    vecs[n_vec].fl     = fl;
    vecs[n_vec].e_ir   = e_ir;
    vecs[n_vec].e_ov   = e_ov;
    vecs[n_vec].e_idx  = e_idx;
    vecs[n_vec].e_last = e_last;
    vecs[n_vec].e_word = e_word;
    n_vec++;
  endtask

  initial begin
    int words_in;
    int cyc;
    beat_t b;
    logic [127:0] w;

    // ---- Directed table: inputs during a cycle, expected outputs that cycle
    //          iv  din ordy fl  ir ov idx last word
    // single word
    add_vec(1, W1, 1, 0,  1, 0, 0, 0, W1);
    add_vec(0, W1, 1, 0,  0, 1, 0, 0, W1);
    add_vec(0, W1, 1, 0,  0, 1, 1, 0, W1);
    add_vec(0, W1, 1, 0,  0, 1, 2, 0, W1);
    add_vec(0, W1, 1, 0,  1, 1, 3, 1, W1);
    add_vec(0, W1, 1, 0,  1, 0, 0, 0, W1);
    // back-to-back, W2 offered continuously
    add_vec(1, W1, 1, 0,  1, 0, 0, 0, W1);
    add_vec(1, W2, 1, 0,  0, 1, 0, 0, W1);
    add_vec(1, W2, 1, 0,  0, 1, 1, 0, W1);
    add_vec(1, W2, 1, 0,  0, 1, 2, 0, W1);
    add_vec(1, W2, 1, 0,  1, 1, 3, 1, W1);
    add_vec(0, W2, 1, 0,  0, 1, 0, 0, W2);
    add_vec(0, W2, 1, 0,  0, 1, 1, 0, W2);
    add_vec(0, W2, 1, 0,  0, 1, 2, 0, W2);
    add_vec(0, W2, 1, 0,  1, 1, 3, 1, W2);
    add_vec(0, W2, 1, 0,  1, 0, 0, 0, W2);
    // backpressure at beat 1 for 5 cycles
    add_vec(1, W1, 1, 0,  1, 0, 0, 0, W1);
    add_vec(0, W1, 1, 0,  0, 1, 0, 0, W1);
    for (int i = 0; i < 5; i++) add_vec(0, W1, 0, 0,  0, 1, 1, 0, W1);
    add_vec(0, W1, 1, 0,  0, 1, 1, 0, W1);
    add_vec(0, W1, 1, 0,  0, 1, 2, 0, W1);
    add_vec(0, W1, 1, 0,  1, 1, 3, 1, W1);
    add_vec(0, W1, 1, 0,  1, 0, 0, 0, W1);
    // flush at beat 2 with a word offered
    add_vec(1, W1, 1, 0,  1, 0, 0, 0, W1);
    add_vec(0, W1, 1, 0,  0, 1, 0, 0, W1);
    add_vec(0, W1, 1, 0,  0, 1, 1, 0, W1);
    add_vec(1, W2, 1, 1,  0, 1, 2, 0, W1);
    add_vec(1, W2, 1, 0,  1, 0, 0, 0, W2);
    add_vec(0, W2, 1, 0,  0, 1, 0, 0, W2);
    // flush in SEND with no word, then flush in IDLE is ignored
    add_vec(0, W2, 1, 1,  0, 1, 1, 0, W2);
    add_vec(1, W1, 1, 1,  1, 0, 0, 0, W1);
    add_vec(0, W1, 1, 0,  0, 1, 0, 0, W1);
    add_vec(0, W1, 1, 0,  0, 1, 1, 0, W1);
    add_vec(0, W1, 1, 0,  0, 1, 2, 0, W1);
    // flush beats a last-beat transfer with a word offered
    add_vec(1, W2, 1, 1,  0, 1, 3, 1, W1);
    add_vec(0, W2, 1, 0,  1, 0, 0, 0, W2);

    // ---- Reset state
    areset_n  = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_idx",   out_idx,   0);
    chk("rst_out_last",  out_last,  0);
    @(negedge clk);
    areset_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- Table-driven vectors
    for (int i = 0; i < n_vec; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].din;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      #1;
      chk($sformatf("v%0d_in_ready", i),  in_ready,  vecs[i].e_ir);
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_out_idx", i),  out_idx,  vecs[i].e_idx);
        chk($sformatf("v%0d_out_last", i), out_last, vecs[i].e_last);
        chk($sformatf("v%0d_out_data", i), out_data,
            exp_beat(vecs[i].e_word, vecs[i].e_idx));
      end
      $display("vec %0d: iv=%0b ordy=%0b fl=%0b -> ir=%0b ov=%0b idx=%0d last=%0b data=%h",
               i, in_valid, out_ready, flush, in_ready, out_valid, out_idx, out_last, out_data);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;

    // ---- Asynchronous reset in the middle of a word (beat 2)
    in_valid  = 1'b1;
    in_data   = W1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_rst_pre_idx", out_idx, 2);
    #2;
    areset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data",  out_data,  0);
    chk("mid_rst_out_idx",   out_idx,   0);
    chk("mid_rst_out_last",  out_last,  0);
    $display("mid-word reset: ov=%0b data=%h idx=%0d last=%0b", out_valid, out_data, out_idx, out_last);
    @(negedge clk);
    areset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_in_ready", i),  in_ready,  1);
      chk($sformatf("post_rst%0d_out_valid", i), out_valid, 0);
    end

    // ---- Random valid/ready stress with a beat scoreboard
    words_in = 0;
    cyc      = 0;
    while ((words_in < 1000 || sb.size() != 0) && cyc < 40000) begin
      in_valid  = (words_in < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("stress_stray_beat", 1, 0);
        end else begin
          b = sb.pop_front();
          chk("stress_data", out_data, b.data);
          chk("stress_idx",  out_idx,  b.idx);
          chk("stress_last", out_last, b.last);
        end
      end
      if (in_valid && in_ready) begin
        w = in_data;
        for (int k = 0; k < 4; k++) begin
          b.idx  = 2'(k);
          b.data = exp_beat(w, b.idx);
          b.last = (k == 3);
          sb.push_back(b);
        end
        words_in++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 40000) begin
      chk("stress_timeout", 1, 0);
    end
    chk("stress_words", words_in, 1000);
    in_valid = 1'b0;
    #1;
    chk("stress_drained_out_valid", out_valid, 0);
    $display("stress: %0d words in %0d cycles, %0d beats left", words_in, cyc, sb.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
